fetch_pc_unit: RTL

- Program-counter and instruction-fetch stage directly upstream of the control unit.
- Holds the PC and fetches one instruction per step over a req/ack instruction-memory handshake.
- Presents the instruction, PC and PCPlus4 to decode/execute, then steps to the next PC using the branch decision (PCSrc) and the immediate (ImmExt).
- Gives the single-cycle datapath a clean fetch/execute boundary while keeping instruction memory latency variable.

---
 rtl/fetch_pc_unit_if.sv | 28 ++
 rtl/fetch_pc_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the decode/execute-facing
// instruction, PC and commit/branch signals.
interface fetch_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            commit;
    logic            PCSrc;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic            misalign;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, PC, PCPlus4, misalign,
        input  imem_ack, imem_rdata, commit, PCSrc, ImmExt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, PC, PCPlus4, misalign,
        output imem_ack, imem_rdata, commit, PCSrc, ImmExt
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and req/ack instruction fetch stage (BOOT -> FETCH -> EXEC loop).
// Optional FETCH_MISALIGN_TRAP_EN: misaligned branch targets halt with a sticky flag.
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_unit_if.master   bus
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
`else
        ST_EXEC  = 2'd2
`endif
    } state_e;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] target_s;
    logic            imem_req_s;
    logic            instr_valid_s;
    logic            misalign_s;
    logic            misalign_d;

    assign pc_plus4_s = pc_q + PC_STEP;
    assign target_s   = bus.PCSrc ? (pc_q + bus.ImmExt) : pc_plus4_s;

    // State, PC and instruction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_s = misalign_q;
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state: capture on ack in FETCH, step PC on commit in EXEC
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_s;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (bus.commit) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target_s[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = target_s;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = target_s & {{(XLEN-2){1'b1}}, 2'b00};
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_s    = 1'b1;
                instr_valid_s = 1'b0;
            end
            ST_EXEC: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b1;
            end
            default: begin
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = imem_req_s;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_s;
    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4_s;
    assign bus.misalign    = misalign_s;
endmodule
